obj_table_ctrl: RTL and testbench

OBJ_TABLE_CTRL -- requirements
Module: obj_table_ctrl

---
 rtl/obj_table_pkg.sv | 20 ++
 rtl/obj_bank.sv | 51 +++++
 rtl/obj_table_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_obj_table_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obj_table_pkg.sv
// Shared types and defaults for the double-buffered object table.
// State encoding, default geometry and coordinate-select codes.
package obj_table_pkg;

  localparam int NUM_OBJ_DEF = 16;
  localparam int COORD_W_DEF = 10;
  localparam int X_MAX_DEF   = 639;
  localparam int Y_MAX_DEF   = 479;
  localparam int IDX_W       = 4;

  localparam logic WR_SEL_X = 1'b0;
  localparam logic WR_SEL_Y = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_COPY  = 2'd2
  } state_t;

endpackage

// File: rtl/obj_bank.sv
// One object table bank: NUM_OBJ (X,Y) entries, one write port
// (independent X/Y enables), two combinational read ports (a, b).
module obj_bank #(
  parameter int NUM_OBJ = 16,
  parameter int COORD_W = 10,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_x,
  input  logic               we_y,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [COORD_W-1:0] wx,
  input  logic [COORD_W-1:0] wy,
  input  logic [IDX_W-1:0]   ra_addr,
  output logic [COORD_W-1:0] ra_x,
  output logic [COORD_W-1:0] ra_y,
  input  logic [IDX_W-1:0]   rb_addr,
  output logic [COORD_W-1:0] rb_x,
  output logic [COORD_W-1:0] rb_y
);

  logic [COORD_W-1:0] x_mem [NUM_OBJ];
  logic [COORD_W-1:0] y_mem [NUM_OBJ];

  logic w_ok;
  logic a_ok;
  logic b_ok;

  assign w_ok = int'(waddr) < NUM_OBJ;
  assign a_ok = int'(ra_addr) < NUM_OBJ;
  assign b_ok = int'(rb_addr) < NUM_OBJ;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_mem[i] <= '0;
        y_mem[i] <= '0;
      end
    end else begin
      if (we_x && w_ok) x_mem[waddr] <= wx;
      if (we_y && w_ok) y_mem[waddr] <= wy;
    end
  end

  assign ra_x = a_ok ? x_mem[ra_addr] : '0;
  assign ra_y = a_ok ? y_mem[ra_addr] : '0;
  assign rb_x = b_ok ? x_mem[rb_addr] : '0;
  assign rb_y = b_ok ? y_mem[rb_addr] : '0;

endmodule

// File: rtl/obj_table_ctrl.sv
// Double-buffered object coordinate table: CPU edits the back bank,
// commit + frame_start swaps banks, then front is copied into back.
// Ports: clk, reset (sync, active-high); store: wr_valid/wr_ready,
// wr_index, wr_sel, wr_data; commit_req, frame_start; rd_index ->
// rd_x/rd_y (registered); commit_pending, swap_done, frame_count.
// Build option: OBJ_CLAMP_EN clamps stores to 0..X_MAX/Y_MAX.
module obj_table_ctrl
  import obj_table_pkg::*;
#(
  parameter int NUM_OBJ = NUM_OBJ_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [3:0]         wr_index,
  input  logic               wr_sel,
  input  logic [31:0]        wr_data,
  input  logic               commit_req,
  input  logic               frame_start,
  input  logic [3:0]         rd_index,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               commit_pending,
  output logic               swap_done,
  output logic [15:0]        frame_count
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBJ - 1);

  state_t state, state_n;

  logic             ptr;
  logic [IDX_W-1:0] cnt;
  logic             latch;
  logic             swap;
  logic             copy_en;
  logic             fire;

  logic [COORD_W-1:0] st_val;
  logic [COORD_W-1:0] ax0, ay0, bx0, by0;
  logic [COORD_W-1:0] ax1, ay1, bx1, by1;
  logic [COORD_W-1:0] f_ax, f_ay, f_bx, f_by;

  logic             we_x, we_y;
  logic [IDX_W-1:0] waddr;
  logic [COORD_W-1:0] wx, wy;
  logic             rd_ok;

`ifdef OBJ_CLAMP_EN
  logic [COORD_W-1:0] lim;

  always_comb begin
    lim = (wr_sel == WR_SEL_Y) ? COORD_W'(Y_MAX)
                               : COORD_W'(X_MAX);
    if (wr_data[31])
      st_val = '0;
    else if (wr_data > 32'(lim))
      st_val = lim;
    else
      st_val = wr_data[COORD_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^wr_data[31:COORD_W];
  assign st_val    = wr_data[COORD_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    wr_ready       = 1'b0;
    commit_pending = 1'b0;
    swap           = 1'b0;
    copy_en        = 1'b0;
    unique case (state)
      S_IDLE: begin
        wr_ready = 1'b1;
        if (commit_req) state_n = S_ARMED;
      end
      S_ARMED: begin
        commit_pending = 1'b1;
        if (frame_start) begin
          swap    = 1'b1;
          state_n = S_COPY;
        end
      end
      S_COPY: begin
        copy_en = 1'b1;
        // A commit on the final copy cycle still re-arms.
        if (cnt == LAST)
          state_n = (latch || commit_req) ? S_ARMED : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= 1'b0;
      cnt         <= '0;
      latch       <= 1'b0;
      swap_done   <= 1'b0;
      frame_count <= '0;
      rd_x        <= '0;
      rd_y        <= '0;
    end else begin
      swap_done   <= swap;
      frame_count <= frame_count + 16'(frame_start);
      if (swap) begin
        ptr <= ~ptr;
        cnt <= '0;
      end else if (copy_en) begin
        cnt <= cnt + 1'b1;
      end
      if (copy_en && state_n != S_COPY)
        latch <= 1'b0;
      else if (copy_en && commit_req)
        latch <= 1'b1;
      // Uses the current ptr, so a same-cycle swap reads pre-swap.
      rd_x <= rd_ok ? f_ax : '0;
      rd_y <= rd_ok ? f_ay : '0;
    end
  end

  assign rd_ok = int'(rd_index) < NUM_OBJ;
  assign fire  = wr_valid && wr_ready;

  assign f_ax = ptr ? ax1 : ax0;
  assign f_ay = ptr ? ay1 : ay0;
  assign f_bx = ptr ? bx1 : bx0;
  assign f_by = ptr ? by1 : by0;

  // All writes target the back bank (bank != ptr).
  assign we_x  = copy_en || (fire && wr_sel == WR_SEL_X);
  assign we_y  = copy_en || (fire && wr_sel == WR_SEL_Y);
  assign waddr = copy_en ? cnt : wr_index;
  assign wx    = copy_en ? f_bx : st_val;
  assign wy    = copy_en ? f_by : st_val;

  obj_bank #(
    .NUM_OBJ (NUM_OBJ),
    .COORD_W (COORD_W),
    .IDX_W   (IDX_W)
  ) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we_x    (we_x && ptr),
    .we_y    (we_y && ptr),
    .waddr   (waddr),
    .wx      (wx),
    .wy      (wy),
    .ra_addr (rd_index),
    .ra_x    (ax0),
    .ra_y    (ay0),
    .rb_addr (cnt),
    .rb_x    (bx0),
    .rb_y    (by0)
  );

  obj_bank #(
    .NUM_OBJ (NUM_OBJ),
    .COORD_W (COORD_W),
    .IDX_W   (IDX_W)
  ) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we_x    (we_x && !ptr),
    .we_y    (we_y && !ptr),
    .waddr   (waddr),
    .wx      (wx),
    .wy      (wy),
    .ra_addr (rd_index),
    .ra_x    (ax1),
    .ra_y    (ay1),
    .rb_addr (cnt),
    .rb_x    (bx1),
    .rb_y    (by1)
  );

endmodule

// File: tb/tb_obj_table_ctrl.sv
// Self-checking bench for obj_table_ctrl: reference model of the
// display/CPU tables plus a read scoreboard queue.
module tb_obj_table_ctrl;
  import obj_table_pkg::*;

  localparam int N  = 16;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_index;
  logic          wr_sel;
  logic [31:0]   wr_data;
  logic          commit_req;
  logic          frame_start;
  logic [3:0]    rd_index;
  logic [CW-1:0] rd_x;
  logic [CW-1:0] rd_y;
  logic          commit_pending;
  logic          swap_done;
  logic [15:0]   frame_count;

  obj_table_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_index       (wr_index),
    .wr_sel         (wr_sel),
    .wr_data        (wr_data),
    .commit_req     (commit_req),
    .frame_start    (frame_start),
    .rd_index       (rd_index),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .commit_pending (commit_pending),
    .swap_done      (swap_done),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] disp_x [N];
  logic [CW-1:0] disp_y [N];
  logic [CW-1:0] cpu_x  [N];
  logic [CW-1:0] cpu_y  [N];
  logic [15:0]   fc;
  logic [2*CW-1:0] rd_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] store_val(
    input logic sel, input logic [31:0] d);
    logic [31:0] lim;
    lim = (sel == WR_SEL_Y) ? 32'd479 : 32'd639;
`ifdef OBJ_CLAMP_EN
    if (d[31]) return '0;
    if (d > lim) return lim[CW-1:0];
    return d[CW-1:0];
`else
    if (lim == 32'd0) return '0;
    return d[CW-1:0];
`endif
  endfunction

  task automatic model_reset;
    for (int i = 0; i < N; i++) begin
      disp_x[i] = '0;
      disp_y[i] = '0;
      cpu_x[i]  = '0;
      cpu_y[i]  = '0;
    end
    fc = '0;
  endtask

  task automatic model_swap;
    for (int i = 0; i < N; i++) begin
      disp_x[i] = cpu_x[i];
      disp_y[i] = cpu_y[i];
    end
  endtask

  task automatic model_store(input int idx,
                             input logic sel,
                             input logic [31:0] d);
    if (idx < N) begin
      if (sel == WR_SEL_Y) cpu_y[idx] = store_val(sel, d);
      else                 cpu_x[idx] = store_val(sel, d);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 64) begin
      tick;
      n++;
    end
  endtask

  task automatic st(input int idx, input logic sel,
                    input logic [31:0] d);
    int n;
    wait_ready(n);
    if (n >= 64) chk("st_timeout", 32'(wr_ready), 1);
    wr_valid = 1'b1;
    wr_index = idx[3:0];
    wr_sel   = sel;
    wr_data  = d;
    tick;
    wr_valid = 1'b0;
    model_store(idx, sel, d);
  endtask

  task automatic rd(input string tag, input int idx);
    logic [2*CW-1:0] e;
    rd_index = idx[3:0];
    rd_q.push_back({disp_x[idx], disp_y[idx]});
    tick;
    e = rd_q.pop_front();
    chk({tag, "_x"}, 32'(rd_x), 32'(e[2*CW-1:CW]));
    chk({tag, "_y"}, 32'(rd_y), 32'(e[CW-1:0]));
  endtask

  task automatic pulse_commit;
    commit_req = 1'b1;
    tick;
    commit_req = 1'b0;
  endtask

  task automatic pulse_frame;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    fc++;
  endtask

  task automatic swap_and_copy(input string tag);
    int n;
    pulse_frame;
    model_swap;
    chk({tag, "_swap"}, 32'(swap_done), 1);
    chk({tag, "_fc"}, 32'(frame_count), 32'(fc));
    wait_ready(n);
    chk({tag, "_copy"}, n, 16);
    chk({tag, "_swap_end"}, 32'(swap_done), 0);
  endtask

  task automatic publish(input string tag);
    pulse_commit;
    chk({tag, "_pend"}, 32'(commit_pending), 1);
    swap_and_copy(tag);
  endtask

  initial begin
    logic [2*CW-1:0] e;
    int n;
    reset       = 1'b1;
    wr_valid    = 1'b0;
    wr_index    = '0;
    wr_sel      = WR_SEL_X;
    wr_data     = '0;
    commit_req  = 1'b0;
    frame_start = 1'b0;
    rd_index    = '0;
    model_reset;
    repeat (3) tick;
    reset = 1'b0;

    chk("rst_rdx", 32'(rd_x), 0);
    chk("rst_rdy", 32'(rd_y), 0);
    chk("rst_swap", 32'(swap_done), 0);
    chk("rst_pend", 32'(commit_pending), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_rdy_wr", 32'(wr_ready), 1);

    // Store, commit, swap with a same-cycle read of the old front.
    st(3, WR_SEL_X, 32'd100);
    pulse_commit;
    chk("c1_pend", 32'(commit_pending), 1);
    chk("c1_rdy", 32'(wr_ready), 0);
    rd_index = 4'd3;
    rd_q.push_back({disp_x[3], disp_y[3]});
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    fc++;
    e = rd_q.pop_front();
    chk("preswap_x", 32'(rd_x), 32'(e[2*CW-1:CW]));
    model_swap;
    chk("c1_swap", 32'(swap_done), 1);
    chk("c1_pend_clr", 32'(commit_pending), 0);
    wait_ready(n);
    chk("c1_copy", n, 16);
    rd("c1_s3", 3);

    // Second publish with no new stores shows the copied back bank.
    publish("c2");
    rd("c2_s3", 3);

    // Store and commit in the same cycle.
    wr_valid   = 1'b1;
    wr_index   = 4'd5;
    wr_sel     = WR_SEL_Y;
    wr_data    = 32'd200;
    commit_req = 1'b1;
    tick;
    wr_valid   = 1'b0;
    commit_req = 1'b0;
    model_store(5, WR_SEL_Y, 32'd200);
    chk("c3_pend", 32'(commit_pending), 1);
    swap_and_copy("c3");
    rd("c3_s5", 5);

    // frame_start without a commit: no swap, counter still moves.
    st(5, WR_SEL_Y, 32'd7);
    pulse_frame;
    chk("nc_swap", 32'(swap_done), 0);
    chk("nc_rdy", 32'(wr_ready), 1);
    chk("nc_fc", 32'(frame_count), 32'(fc));
    rd("nc_s5", 5);

    // Store value boundaries.
    st(0, WR_SEL_X, 32'hFFFF_FFFF);
    st(1, WR_SEL_X, 32'd700);
    st(2, WR_SEL_Y, 32'd700);
    st(4, WR_SEL_Y, 32'h1234_5678);
    st(15, WR_SEL_X, 32'd555);
    st(6, WR_SEL_X, 32'd639);
    publish("c4");
    rd("c4_s0", 0);
    rd("c4_s1", 1);
    rd("c4_s2", 2);
    rd("c4_s4", 4);
    rd("c4_s15", 15);
    rd("c4_s6", 6);

    // Reset in the middle of a copy.
    st(9, WR_SEL_X, 32'd77);
    pulse_commit;
    pulse_frame;
    repeat (5) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_reset;
    chk("mr_rdx", 32'(rd_x), 0);
    chk("mr_rdy", 32'(rd_y), 0);
    chk("mr_swap", 32'(swap_done), 0);
    chk("mr_pend", 32'(commit_pending), 0);
    chk("mr_fc", 32'(frame_count), 0);
    chk("mr_wr_rdy", 32'(wr_ready), 1);
    rd("mr_s3", 3);
    rd("mr_s9", 9);
    publish("mr");
    rd("mr2_s3", 3);
    rd("mr2_s15", 15);

    // Frame counter wrap.
    fc = frame_count;
    frame_start = 1'b1;
    repeat (65535) begin
      tick;
      fc++;
    end
    frame_start = 1'b0;
    chk("fc_pre", 32'(frame_count), 32'(fc));
    pulse_frame;
    chk("fc_wrap", 32'(frame_count), 32'(fc));
    chk("fc_wrap_swap", 32'(swap_done), 0);

    // Commit during COPY re-arms; next frame_start swaps again.
    st(7, WR_SEL_X, 32'd321);
    pulse_commit;
    pulse_frame;
    model_swap;
    chk("rc_swap", 32'(swap_done), 1);
    repeat (3) tick;
    commit_req = 1'b1;
    tick;
    commit_req = 1'b0;
    n = 0;
    while (!commit_pending && n < 64) begin
      tick;
      n++;
    end
    chk("rc_pend", 32'(commit_pending), 1);
    chk("rc_rdy", 32'(wr_ready), 0);
    rd("rc_s7a", 7);
    swap_and_copy("rc");
    rd("rc_s7b", 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
